// File: rtl/axi_uart_lite_driver.sv
// AXI-Lite initiator driving a UART-Lite register block: Tx bytes go out through Status-gated FIFO writes, Rx bytes are drained into a stream.
// Optional macro UART_DRV_IRQ_EN: adds uart_irq_i, sets the interrupt enable in Ctrl and replaces the poll timer with the interrupt.
module axi_uart_lite_driver #(
    parameter logic [12:0] BASE_ADDR     = 13'h0000,
    parameter int          POLL_INTERVAL = 16,
    parameter logic [31:0] INIT_CTRL     = 32'h3
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    output logic [12:0] m_axi_uart_awaddr,
    output logic        m_axi_uart_awvalid,
    input  logic        m_axi_uart_awready,
    output logic [31:0] m_axi_uart_wdata,
    output logic [3:0]  m_axi_uart_wstrb,
    output logic        m_axi_uart_wvalid,
    input  logic        m_axi_uart_wready,
    input  logic [1:0]  m_axi_uart_bresp,
    input  logic        m_axi_uart_bvalid,
    output logic        m_axi_uart_bready,
    output logic [12:0] m_axi_uart_araddr,
    output logic        m_axi_uart_arvalid,
    input  logic        m_axi_uart_arready,
    input  logic [31:0] m_axi_uart_rdata,
    input  logic [1:0]  m_axi_uart_rresp,
    input  logic        m_axi_uart_rvalid,
    output logic        m_axi_uart_rready,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
`ifdef UART_DRV_IRQ_EN
    input  logic        uart_irq_i,
`endif
    output logic        err_o
);

`ifdef UART_DRV_IRQ_EN
    localparam logic [31:0] CTRL_VAL = INIT_CTRL | 32'h10;
`else
    localparam logic [31:0] CTRL_VAL = INIT_CTRL;
`endif

    typedef enum logic [3:0] {
        S_INIT_WR, S_INIT_B, S_POLL_AR, S_POLL_R, S_POLL_DEC,
        S_TX_WR, S_TX_B, S_RX_AR, S_RX_R, S_WAIT
    } state_t;

    state_t      state, state_nxt;
    logic        run_q, aw_done, w_done;
    logic        tx_full;
    logic [7:0]  tx_byte;
    logic [4:0]  stat;
    logic        is_wr, aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_last, wait_done;
    logic        unused_bits;

    assign is_wr = (state == S_INIT_WR) || (state == S_TX_WR);

    // run_q keeps the write valids low for the first cycle out of reset
    assign m_axi_uart_awvalid = run_q && is_wr && !aw_done;
    assign m_axi_uart_wvalid  = run_q && is_wr && !w_done;
    assign m_axi_uart_bready  = (state == S_INIT_B) || (state == S_TX_B);
    assign m_axi_uart_arvalid = (state == S_POLL_AR) || (state == S_RX_AR);
    assign m_axi_uart_rready  = (state == S_POLL_R) || (state == S_RX_R);

    assign m_axi_uart_awaddr = (state == S_TX_WR) ? BASE_ADDR + 13'h004 : BASE_ADDR + 13'h00C;
    assign m_axi_uart_wdata  = (state == S_TX_WR) ? {24'h0, tx_byte} : CTRL_VAL;
    assign m_axi_uart_wstrb  = (state == S_TX_WR) ? 4'b0001 : 4'b1111;
    assign m_axi_uart_araddr = (state == S_RX_AR) ? BASE_ADDR : BASE_ADDR + 13'h008;

    assign aw_hs   = m_axi_uart_awvalid && m_axi_uart_awready;
    assign w_hs    = m_axi_uart_wvalid && m_axi_uart_wready;
    assign b_hs    = m_axi_uart_bvalid && m_axi_uart_bready;
    assign ar_hs   = m_axi_uart_arvalid && m_axi_uart_arready;
    assign r_hs    = m_axi_uart_rvalid && m_axi_uart_rready;
    assign wr_last = is_wr && (aw_done || aw_hs) && (w_done || w_hs);

    assign tx_ready_o  = !tx_full && (state != S_INIT_WR) && (state != S_INIT_B);
    assign unused_bits = ^{m_axi_uart_rdata[31:8], stat[4], stat[2:1]};

`ifdef UART_DRV_IRQ_EN
    assign wait_done = uart_irq_i || tx_full;
`else
    localparam int          CNT_W    = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_INTERVAL - 1);

    logic [CNT_W-1:0] cnt;

    // a held byte leaves early, but only after one counted cycle so a Tx-full poll is never back-to-back
    assign wait_done = (cnt == CNT_LAST) || (tx_full && (cnt != '0));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            cnt <= '0;
        else if (state == S_WAIT && !wait_done)
            cnt <= cnt + 1'b1;
        else
            cnt <= '0;
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT_WR:  if (wr_last) state_nxt = S_INIT_B;
            S_INIT_B:   if (b_hs)    state_nxt = S_POLL_AR;
            S_POLL_AR:  if (ar_hs)   state_nxt = S_POLL_R;
            S_POLL_R:   if (r_hs)    state_nxt = S_POLL_DEC;
            S_POLL_DEC: begin
                if (tx_full && !stat[3])
                    state_nxt = S_TX_WR;
                else if (stat[0] && !rx_valid_o)
                    state_nxt = S_RX_AR;
                else
                    state_nxt = S_WAIT;
            end
            S_TX_WR:    if (wr_last)   state_nxt = S_TX_B;
            S_TX_B:     if (b_hs)      state_nxt = S_POLL_AR;
            S_RX_AR:    if (ar_hs)     state_nxt = S_RX_R;
            S_RX_R:     if (r_hs)      state_nxt = S_POLL_AR;
            S_WAIT:     if (wait_done) state_nxt = S_POLL_AR;
            default:    state_nxt = S_INIT_WR;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= S_INIT_WR;
            run_q      <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            tx_full    <= 1'b0;
            rx_valid_o <= 1'b0;
            rx_data_o  <= 8'h00;
            err_o      <= 1'b0;
        end else begin
            state <= state_nxt;
            run_q <= 1'b1;
            if (wr_last) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
            // a failed Tx write still frees the holding register
            if (state == S_TX_B && b_hs)
                tx_full <= 1'b0;
            else if (tx_valid_i && tx_ready_o)
                tx_full <= 1'b1;
            if (state == S_RX_R && r_hs && m_axi_uart_rresp == 2'b00) begin
                rx_valid_o <= 1'b1;
                rx_data_o  <= m_axi_uart_rdata[7:0];
            end else if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
            if ((b_hs && m_axi_uart_bresp != 2'b00) || (r_hs && m_axi_uart_rresp != 2'b00))
                err_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (tx_valid_i && tx_ready_o)
            tx_byte <= tx_data_i;
        if (state == S_POLL_R && r_hs)
            stat <= m_axi_uart_rdata[4:0];
    end

endmodule

// File: tb/tb_axi_uart_lite_driver.sv
// Bench for axi_uart_lite_driver: a reactive UART-Lite slave model driven on the falling edge plus directed console traffic.
module tb_axi_uart_lite_driver;

    logic        clk, rstn;
    logic [12:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [7:0]  tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, err;

    axi_uart_lite_driver dut (
        .clk_i(clk), .rstn_i(rstn),
        .m_axi_uart_awaddr(awaddr), .m_axi_uart_awvalid(awvalid), .m_axi_uart_awready(awready),
        .m_axi_uart_wdata(wdata), .m_axi_uart_wstrb(wstrb), .m_axi_uart_wvalid(wvalid),
        .m_axi_uart_wready(wready), .m_axi_uart_bresp(bresp), .m_axi_uart_bvalid(bvalid),
        .m_axi_uart_bready(bready), .m_axi_uart_araddr(araddr), .m_axi_uart_arvalid(arvalid),
        .m_axi_uart_arready(arready), .m_axi_uart_rdata(rdata), .m_axi_uart_rresp(rresp),
        .m_axi_uart_rvalid(rvalid), .m_axi_uart_rready(rready),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready), .err_o(err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // slave model state
    bit          p_aw, p_w, p_b, p_ar, p_r, aw_got, w_got, ar_got, prev_bready;
    bit          held, full, berr_next, tx_rdy_at_b, tx_rdy_after_b;
    logic [12:0] cur_awaddr, cur_araddr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_wstrb;
    logic [1:0]  last_bresp;
    logic [7:0]  rxb;
    logic [12:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [3:0]  wr_strb_q[$];
    logic [7:0]  rx_q[$];
    int wcnt, bcnt, w_delay, b_delay, wr_cnt, rd_cnt, stat_rd_cnt, rx_rd_cnt;
    int held_polls, txfull_left, early_bready, bready_drop, wphase_bad;
    int w_stall, w_stall_max, rd_at_first_wr, last_held_cyc, min_gap;

    initial begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        w_delay = 0; b_delay = 0; berr_next = 0; wr_cnt = 0; rd_cnt = 0; stat_rd_cnt = 0; rx_rd_cnt = 0;
        held_polls = 0; txfull_left = 0; early_bready = 0; bready_drop = 0; wphase_bad = 0;
        w_stall = 0; w_stall_max = 0; rd_at_first_wr = -1; last_held_cyc = -1; min_gap = 1000;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
                aw_got = 0; w_got = 0; ar_got = 0; wcnt = 0; bcnt = 0; prev_bready = 0;
            end else begin
                // commit handshakes that fired on the rising edge just passed
                if (p_aw) aw_got = 1;
                if (p_w)  w_got = 1;
                if (p_b) begin
                    wr_cnt++;
                    wr_addr_q.push_back(cur_awaddr);
                    wr_data_q.push_back(cur_wdata);
                    wr_strb_q.push_back(cur_wstrb);
                    last_bresp = bresp;
                    if (wr_cnt == 1) rd_at_first_wr = rd_cnt;
                    if (cur_awaddr == 13'h004) begin
                        tx_rdy_after_b = tx_ready;
                        berr_next = 0;
                    end
                    if (w_stall > w_stall_max) w_stall_max = w_stall;
                    w_stall = 0;
                    aw_got = 0; w_got = 0; bvalid = 0; wcnt = 0; bcnt = 0;
                end
                if (p_ar) begin ar_got = 1; rd_cnt++; end
                if (p_r)  begin ar_got = 0; rvalid = 0; end
                if (bready && !(aw_got && w_got)) early_bready++;
                if (prev_bready && !p_b && !bready) bready_drop++;
                prev_bready = bready;
                if (aw_got && !w_got) begin
                    wcnt++;
                    w_stall++;
                    if (awvalid || !wvalid || bready) wphase_bad++;
                end
                awready = awvalid && !aw_got;
                wready  = wvalid && !w_got && (w_delay == 0 || (aw_got && wcnt >= w_delay));
                if (aw_got && w_got && !bvalid) begin
                    if (bcnt >= b_delay) begin
                        bvalid = 1;
                        bresp  = (berr_next && cur_awaddr == 13'h004) ? 2'b10 : 2'b00;
                    end else begin
                        bcnt++;
                    end
                end
                arready = arvalid && !ar_got;
                if (ar_got && !rvalid) begin
                    rvalid = 1;
                    rresp  = 2'b00;
                    if (cur_araddr == 13'h008) begin
                        held = !tx_ready || tx_valid;
                        full = held && (txfull_left > 0);
                        if (full) txfull_left--;
                        rdata = {27'h0, 1'b0, full, !full, 1'b0, (rx_q.size() > 0)};
                        stat_rd_cnt++;
                        if (held) begin
                            held_polls++;
                            if (last_held_cyc >= 0 && (cyc - last_held_cyc) < min_gap) min_gap = cyc - last_held_cyc;
                            last_held_cyc = cyc;
                        end else begin
                            last_held_cyc = -1;
                        end
                    end else begin
                        rxb = 8'h00;
                        if (rx_q.size() > 0) rxb = rx_q.pop_front();
                        rdata = {24'h0, rxb};
                        rx_rd_cnt++;
                    end
                end
                // handshakes that will fire on the next rising edge
                p_aw = awvalid && awready;
                if (p_aw) cur_awaddr = awaddr;
                p_w = wvalid && wready;
                if (p_w) begin cur_wdata = wdata; cur_wstrb = wstrb; end
                p_b = bvalid && bready;
                if (p_b && cur_awaddr == 13'h004) tx_rdy_at_b = tx_ready;
                p_ar = arvalid && arready;
                if (p_ar) cur_araddr = araddr;
                p_r = rvalid && rready;
            end
        end
    end

    task automatic push(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1;
        for (int k = 0; k < 300 && !tx_ready; k++) begin
            @(posedge clk); #1;
        end
        check_val("push_accept", tx_ready, 1'b1);
        @(posedge clk); #1;
        tx_valid = 0;
    endtask

    task automatic wait_wr(input string tag, input int target);
        for (int k = 0; k < 800 && wr_cnt < target; k++) begin
            @(posedge clk); #1;
        end
        check_val(tag, wr_cnt, target);
    endtask

    task automatic wait_rx(input string tag);
        for (int k = 0; k < 200 && !rx_valid; k++) begin
            @(posedge clk); #1;
        end
        check_val(tag, rx_valid, 1'b1);
    endtask

    int base, lat, unstable, rx_base;

    initial begin
        rstn = 0; tx_valid = 0; tx_data = 0; rx_ready = 0;
        b_delay = 3;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_awvalid", awvalid, 1'b0);
        check_val("rst_wvalid", wvalid, 1'b0);
        check_val("rst_bready", bready, 1'b0);
        check_val("rst_arvalid", arvalid, 1'b0);
        check_val("rst_rready", rready, 1'b0);
        check_val("rst_tx_ready", tx_ready, 1'b0);
        check_val("rst_rx_valid", rx_valid, 1'b0);
        check_val("rst_rx_data", rx_data, 8'h00);
        check_val("rst_err", err, 1'b0);
        rstn = 1;

        // Ctrl init write, B delayed so bready must wait for bvalid
        wait_wr("init_wr_done", 1);
        check_val("init_awaddr", wr_addr_q[0], 13'h00C);
        check_val("init_wdata", wr_data_q[0], 32'h3);
        check_val("init_wstrb", wr_strb_q[0], 4'hF);
        check_val("init_first_txn", rd_at_first_wr, 0);
        check_val("init_early_bready", early_bready, 0);
        check_val("init_bready_drop", bready_drop, 0);
        check_val("init_err", err, 1'b0);
        b_delay = 0;
        repeat (5) @(posedge clk);
        #1;

        // plain Tx byte, Status empty
        base = stat_rd_cnt;
        push(8'h41);
        lat = 1;
        for (int k = 0; k < 40 && !awvalid; k++) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("tx_latency_ok", (lat <= 20), 1'b1);
        wait_wr("tx41_done", 2);
        check_val("tx41_awaddr", wr_addr_q[$], 13'h004);
        check_val("tx41_wdata", wr_data_q[$], 32'h41);
        check_val("tx41_wstrb", wr_strb_q[$], 4'h1);
        check_val("tx41_polled", (stat_rd_cnt > base), 1'b1);
        check_val("tx41_ready_at_b", tx_rdy_at_b, 1'b0);
        check_val("tx41_ready_after_b", tx_rdy_after_b, 1'b1);

        // Tx FIFO full for three polls
        repeat (3) @(posedge clk);
        #1;
        held_polls = 0; last_held_cyc = -1; min_gap = 1000;
        txfull_left = 3;
        push(8'h42);
        wait_wr("tx42_done", 3);
        check_val("tx42_polls", held_polls, 4);
        check_val("tx42_full_used", txfull_left, 0);
        check_val("tx42_wdata", wr_data_q[$], 32'h42);
        check_val("tx42_poll_gap_ok", (min_gap >= 4 && min_gap < 1000), 1'b1);

        // Rx drain with back-pressure
        rx_base = rx_rd_cnt;
        rx_q.push_back(8'h5A);
        rx_q.push_back(8'h5B);
        wait_rx("rx5a_valid");
        check_val("rx5a_data", rx_data, 8'h5A);
        unstable = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (!rx_valid || rx_data != 8'h5A) unstable++;
        end
        check_val("rx5a_stable", unstable, 0);
        check_val("rx5a_single_read", rx_rd_cnt - rx_base, 1);
        check_val("rx5a_fifo_left", rx_q.size(), 1);
        rx_ready = 1;
        @(posedge clk); #1;
        rx_ready = 0;
        check_val("rx5a_cleared", rx_valid, 1'b0);
        wait_rx("rx5b_valid");
        check_val("rx5b_data", rx_data, 8'h5B);
        rx_ready = 1;
        @(posedge clk); #1;
        rx_ready = 0;

        // W channel stalls behind AW
        w_delay = 5; w_stall_max = 0; early_bready = 0;
        push(8'h43);
        wait_wr("tx43_done", 4);
        check_val("tx43_wdata", wr_data_q[$], 32'h43);
        check_val("tx43_wphase", wphase_bad, 0);
        check_val("tx43_stalled", (w_stall_max >= 5), 1'b1);
        check_val("tx43_early_bready", early_bready, 0);
        w_delay = 0;

        // SLVERR on a Tx write
        berr_next = 1;
        push(8'h44);
        wait_wr("tx44_done", 5);
        repeat (2) @(posedge clk);
        #1;
        check_val("tx44_wdata", wr_data_q[$], 32'h44);
        check_val("tx44_err", err, 1'b1);
        check_val("tx44_freed", tx_ready, 1'b1);
        push(8'h45);
        wait_wr("tx45_done", 6);
        check_val("tx45_wdata", wr_data_q[$], 32'h45);
        check_val("tx45_bresp", last_bresp, 2'b00);
        check_val("tx45_err_sticky", err, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
